// File: rtl/regblock_window_acc.sv
// Groups enabled q samples into windows of WINDOW samples and queues a
// {sum, max, seq} record per window in a small FIFO behind a valid/ready port.
module regblock_window_acc #(
   parameter int WIDTH  = 32,
   parameter int WINDOW = 4,
   parameter int ACC_W  = 40,
   parameter int DEPTH  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] q,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [WIDTH-1:0] out_max,
   output logic [7:0]       out_seq,
   output logic [7:0]       drop_cnt,
   output logic             busy
);

   localparam int CW = $clog2(WINDOW);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NW = $clog2(DEPTH + 1);
   localparam int RW = ACC_W + WIDTH + 8;
   localparam logic [CW-1:0] LAST     = CW'(WINDOW - 1);
   localparam logic [NW-1:0] FULL     = NW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   typedef enum logic {IDLE, ACC} state_t;

   // Handshake: a record transfers on a rising edge where out_valid && out_ready;
   // the head record and out_valid are held until that transfer happens.
   typedef struct packed {
      state_t        state;
      logic [CW-1:0] count;
   } dbg_t;

   state_t           state, state_n;
   logic [CW-1:0]    count, count_n;
   logic [ACC_W-1:0] sum_r, sum_n;
   logic [WIDTH-1:0] max_r, max_n, upd_max;
   logic [7:0]       seq_r;
   logic [7:0]       drop_r;
   logic             push, pop, push_ok;
   logic [RW-1:0]    rec_n;
   dbg_t             dbg;

   logic [RW-1:0]    mem [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [NW-1:0]    fcnt;
   logic [RW-1:0]    last_rec;
   logic [RW-1:0]    head;

   assign dbg.state = state;
   assign dbg.count = count;
   assign upd_max   = (q > max_r) ? q : max_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         sum_r <= '0;
         max_r <= '0;
      end else begin
         state <= state_n;
         count <= count_n;
         sum_r <= sum_n;
         max_r <= max_n;
      end
   end

   always_comb begin
      state_n = state;
      count_n = count;
      sum_n   = sum_r;
      max_n   = max_r;
      push    = 1'b0;
      rec_n   = '0;
      case (state)
         IDLE: begin
            if (en) begin
               state_n = ACC;
               sum_n   = ACC_W'(q);
               max_n   = q;
               count_n = CW'(1);
            end
         end
         ACC: begin
            if (en) begin
               if (dbg.count == LAST) begin
                  push    = 1'b1;
                  rec_n   = {sum_r + ACC_W'(q), upd_max, seq_r};
                  state_n = IDLE;
                  count_n = '0;
                  sum_n   = '0;
                  max_n   = '0;
               end else begin
                  sum_n   = sum_r + ACC_W'(q);
                  max_n   = upd_max;
                  count_n = count + CW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign pop     = (fcnt != '0) && out_ready;
   assign push_ok = push && ((fcnt != FULL) || pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fcnt     <= '0;
         last_rec <= '0;
         seq_r    <= '0;
         drop_r   <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= rec_n;
            wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
         end
         if (pop) begin
            last_rec <= mem[rd_ptr];
            rd_ptr   <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
         end
         case ({push_ok, pop})
            2'b10:   fcnt <= fcnt + NW'(1);
            2'b01:   fcnt <= fcnt - NW'(1);
            default: fcnt <= fcnt;
         endcase
         if (push) seq_r <= seq_r + 8'd1;
         if (push && !push_ok && (drop_r != 8'hFF)) drop_r <= drop_r + 8'd1;
      end
   end

   // With the FIFO empty the outputs keep showing the last record consumed.
   assign head      = (fcnt != '0) ? mem[rd_ptr] : last_rec;
   assign out_sum   = head[RW-1 -: ACC_W];
   assign out_max   = head[WIDTH+7 -: WIDTH];
   assign out_seq   = head[7:0];
   assign out_valid = (fcnt != '0);
   assign drop_cnt  = drop_r;
   assign busy      = (dbg.state == ACC) || out_valid;

endmodule

// File: tb/tb_regblock_window_acc.sv
// Directed bench for regblock_window_acc: expected records go into a queue,
// a negedge monitor pops and compares every record the DUT hands over.
module tb_regblock_window_acc;

   localparam int RW = 80;

   logic        clk = 1'b0;
   logic        rst, en, out_ready, out_valid, busy;
   logic [31:0] q, out_max;
   logic [39:0] out_sum;
   logic [7:0]  out_seq, drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] mon_e;

   always #5 clk = ~clk;

   regblock_window_acc dut (
      .clk(clk), .rst(rst), .en(en), .q(q),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_max(out_max), .out_seq(out_seq),
      .drop_cnt(drop_cnt), .busy(busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge, so they are stable at both edges.
   task automatic cyc(input logic e, input logic [31:0] v);
      en = e;
      q  = v;
      @(posedge clk);
      #1;
   endtask

   task automatic window4(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d);
      cyc(1'b1, a);
      cyc(1'b1, b);
      cyc(1'b1, c);
      cyc(1'b1, d);
   endtask

   task automatic expect_rec(input logic [39:0] s, input logic [31:0] m, input logic [7:0] sq);
      exp_q.push_back({s, m, sq});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 32'd0);
      rst = 1'b0;
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_record: got seq %0d, want none", out_seq);
         end else begin
            mon_e = exp_q.pop_front();
            check("rec_sum", out_sum, mon_e[79:40]);
            check("rec_max", out_max, mon_e[39:8]);
            check("rec_seq", out_seq, mon_e[7:0]);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b0; q = '0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b0, 32'd0);
      rst = 1'b0;
      check("rst_valid", out_valid, 0);
      check("rst_sum", out_sum, 0);
      check("rst_max", out_max, 0);
      check("rst_seq", out_seq, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_busy", busy, 0);

      // basic window
      out_ready = 1'b1;
      expect_rec(40'd10, 32'd4, 8'd0);
      cyc(1'b1, 32'd1);
      cyc(1'b1, 32'd2);
      cyc(1'b1, 32'd3);
      check("t1_no_early_valid", out_valid, 0);
      cyc(1'b1, 32'd4);
      check("t1_valid", out_valid, 1);
      cyc(1'b0, 32'd0);
      check("t1_valid_one_cycle", out_valid, 0);
      check("t1_busy_after", busy, 0);
      check("t1_hold_sum", out_sum, 10);

      // en gaps pause the window
      expect_rec(40'd23, 32'd9, 8'd1);
      cyc(1'b1, 32'd5);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 32'hDEAD_BEEF);
         check("t2_pause_busy", busy, 1);
         check("t2_pause_valid", out_valid, 0);
      end
      cyc(1'b1, 32'd9);
      cyc(1'b1, 32'd2);
      check("t2_no_early_valid", out_valid, 0);
      cyc(1'b1, 32'd7);
      check("t2_valid", out_valid, 1);
      cyc(1'b0, 32'd0);

      // full FIFO drops the third window
      do_reset();
      out_ready = 1'b0;
      expect_rec(40'h3_FFFF_FFFC, 32'hFFFF_FFFF, 8'd0);
      expect_rec(40'h3_FFFF_FFFC, 32'hFFFF_FFFF, 8'd1);
      for (int w = 0; w < 3; w++) window4('1, '1, '1, '1);
      check("t3_drop", drop_cnt, 1);
      check("t3_valid", out_valid, 1);
      check("t3_busy", busy, 1);
      cyc(1'b0, 32'd0);
      cyc(1'b0, 32'd0);
      check("t3_hold_seq", out_seq, 0);
      check("t3_hold_sum", out_sum, 40'h3_FFFF_FFFC);
      out_ready = 1'b1;
      cyc(1'b0, 32'd0);
      cyc(1'b0, 32'd0);
      check("t3_drained", out_valid, 0);
      expect_rec(40'd4, 32'd1, 8'd3);
      window4(1, 1, 1, 1);
      cyc(1'b0, 32'd0);
      check("t3_drop_kept", drop_cnt, 1);

      // pop on the completing edge makes room for the push
      do_reset();
      out_ready = 1'b0;
      expect_rec(40'd10, 32'd4, 8'd0);
      expect_rec(40'd100, 32'd40, 8'd1);
      expect_rec(40'd28, 32'd7, 8'd2);
      window4(1, 2, 3, 4);
      window4(10, 20, 30, 40);
      cyc(1'b1, 32'd7);
      cyc(1'b1, 32'd7);
      cyc(1'b1, 32'd7);
      out_ready = 1'b1;
      cyc(1'b1, 32'd7);
      check("t4_no_drop", drop_cnt, 0);
      check("t4_head_seq", out_seq, 1);
      cyc(1'b0, 32'd0);
      cyc(1'b0, 32'd0);
      check("t4_drained", out_valid, 0);
      check("t4_busy", busy, 0);

      // reset mid-window and mid-handshake
      do_reset();
      out_ready = 1'b0;
      window4(1, 2, 3, 4);
      cyc(1'b1, 32'd100);
      cyc(1'b1, 32'd200);
      check("t5_pre_valid", out_valid, 1);
      check("t5_pre_busy", busy, 1);
      rst = 1'b1;
      cyc(1'b1, 32'd999);
      rst = 1'b0;
      exp_q.delete();
      check("t5_valid", out_valid, 0);
      check("t5_busy", busy, 0);
      check("t5_drop", drop_cnt, 0);
      check("t5_seq", out_seq, 0);
      check("t5_sum", out_sum, 0);
      out_ready = 1'b1;
      expect_rec(40'd14, 32'd5, 8'd0);
      window4(2, 3, 4, 5);
      cyc(1'b0, 32'd0);
      check("t5_busy_after", busy, 0);

      // drop counter saturation and window counter wrap
      do_reset();
      out_ready = 1'b0;
      expect_rec(40'd4, 32'd1, 8'd0);
      expect_rec(40'd4, 32'd1, 8'd1);
      window4(1, 1, 1, 1);
      window4(1, 1, 1, 1);
      for (int w = 0; w < 254; w++) window4(5, 5, 5, 5);
      check("t6_drop_254", drop_cnt, 254);
      window4(5, 5, 5, 5);
      check("t6_drop_255", drop_cnt, 255);
      window4(5, 5, 5, 5);
      check("t6_drop_sat", drop_cnt, 255);
      out_ready = 1'b1;
      cyc(1'b0, 32'd0);
      cyc(1'b0, 32'd0);
      check("t6_drained", out_valid, 0);
      expect_rec(40'd12, 32'd6, 8'd2);
      window4(6, 2, 3, 1);
      cyc(1'b0, 32'd0);
      check("t6_drop_final", drop_cnt, 255);

      check("exp_q_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regblock_window_acc.md
Name: regblock_window_acc

Overview:
- Downstream consumer of the regblock `q` stream.
- Samples `q` on enabled cycles and groups samples into fixed windows of WINDOW samples.
- For each completed window, emits a record {sum, max, sequence number} through a small output FIFO with a valid/ready handshake.
- Used standalone and instantiated per-copy inside two-trace miters, so every state element is reset deterministically.

Parameters:
- WIDTH, 32, width of the sampled `q` word.
- WINDOW, 4, samples per window; must be at least 2.
- ACC_W, 40, sum width; must be at least WIDTH+$clog2(WINDOW).
- DEPTH, 2, output FIFO entries; must be at least 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; `q` is sampled on posedge when en=1.
- q  input  WIDTH  data from regblock, unsigned.
- out_valid  output  1  FIFO head record valid.
- out_ready  input  1  consumer accepts the head record.
- out_sum  output  ACC_W  sum of the window samples.
- out_max  output  WIDTH  unsigned maximum of the window samples.
- out_seq  output  8  window sequence number.
- drop_cnt  output  8  saturating count of windows dropped because the FIFO was full.
- busy  output  1  a window is in progress or the FIFO is non-empty.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; sample count=0; partial sum=0; partial max=0; window counter=0; FIFO emptied.
  - Outputs after reset: out_valid=0, out_sum=0, out_max=0, out_seq=0, drop_cnt=0, busy=0.
  - rst has priority over every other event, including mid-window and mid-handshake; the partial window is discarded.
- FSM, two states:
  - IDLE: no partial window.
    - en=1 → ACC; load sum=q, max=q, count=1.
  - ACC: count samples taken, 1..WINDOW-1.
    - en=0: hold all state (pause; the window resumes on the next en=1).
    - en=1 and count<WINDOW-1: sum+=q, max=max(max,q), count++.
    - en=1 and count==WINDOW-1: the window completes.
      - Form the record {sum+q, max(max,q), window counter}.
      - Attempt a FIFO push; return to IDLE; increment the window counter (mod 256).
- Window counter:
  - Increments on every completed window, accepted or dropped.
  - Gaps in out_seq therefore expose drops.
- Arithmetic:
  - Sum is zero-extended unsigned addition, modulo 2^ACC_W. It cannot overflow when the ACC_W constraint holds.
  - Max uses an unsigned compare; ties keep the value.
- Push latency: a record completed at posedge N is visible at the FIFO head no earlier than after posedge N (same-cycle completion registered). If the FIFO was empty, out_valid=1 in cycle N+1.
- FIFO:
  - In-order; a pop occurs when out_valid && out_ready.
  - Push with FIFO full and no simultaneous pop: record dropped; drop_cnt increments, saturating at 255.
  - Push with FIFO full and a simultaneous pop: push accepted, occupancy unchanged.
  - Simultaneous push and pop on an empty FIFO cannot occur, because out_valid=0.
- Output hold rule:
  - While out_valid=1 and out_ready=0, out_sum, out_max and out_seq stay stable.
  - out_valid does not drop until the record is popped.
- Empty FIFO outputs: out_sum, out_max and out_seq hold the last popped values (0 after reset).
- busy = (state==ACC) || (FIFO count != 0).
- Input assumptions: `q` has no backpressure, and out_ready may toggle freely.

Test Plan:
1. Reset, then en=1 with q=1,2,3,4 and out_ready=1 → out_valid=1 for one cycle, the cycle after sample 4; out_sum=10, out_max=4, out_seq=0; busy=0 afterwards.
2. q=5,X(en=0 for 3 cycles),9,2,7 → en gaps pause the window; record out_sum=23, out_max=9; out_valid appears only after the 4th enabled sample.
3. out_ready=0, 3 windows of q=0xFFFFFFFF → the first 2 records are queued with sum=0x3FFFFFFFC, seq 0,1; the 3rd is dropped with drop_cnt=1; raising out_ready yields seq 0 then 1, and the next window has seq 3.
4. FIFO full, out_ready=1 exactly on the cycle the 3rd window completes → no drop (drop_cnt=0); the popped seq 0 is followed by seq 1 and then seq 2.
5. rst asserted after 2 samples of a window and while a record is queued with out_ready=0 → next cycle out_valid=0, busy=0, drop_cnt=0; the next window restarts with out_seq=0 and the partial samples are not included.
6. Force 256 drops with out_ready=0 → drop_cnt saturates at 255; the window counter wraps 255→0.
